// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control unit for the zepto core.
// Owns the PC and instruction register, fetches from imem, hands the opcode
// to the PC-select mux, commits its next-PC result in EXEC and sequences
// dmem access and regfile writeback per opcode class.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/addr/ready/rdata instruction fetch handshake
//   ir_out, opcode_out        latched instruction and its opcode
//   pc_out, next_pc_in        current PC out, next PC from the PC mux
//   dmem_req/we/ready         data access handshake
//   rf_we, wb_sel             regfile write strobe and writeback source
//   retire, halted, illegal   status strobes
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'b1111,
  parameter logic [3:0]  LOAD_OP  = 4'b1000,
  parameter logic [3:0]  STORE_OP = 4'b1010
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir_out,
  output logic [3:0]  opcode_out,
  output logic [15:0] pc_out,
  input  logic [15:0] next_pc_in,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        halted,
  output logic        illegal
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [1:0]  r_wb_sel;

  logic [3:0] w_op;
  logic       w_halt_op;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_to_mem;
  logic       w_to_wb;
  logic       w_is_illegal;
  logic       w_fetch;
  logic       w_exec;
  logic       w_mem;
  logic       w_wb;
  logic [1:0] w_wb_sel;

  assign w_op         = r_ir[15:12];
  assign w_halt_op    = w_op == HALT_OP;
  assign w_is_load    = w_op == LOAD_OP;
  assign w_is_store   = w_op == STORE_OP;
  assign w_to_mem     = !w_halt_op && (w_is_load || w_is_store);
  assign w_to_wb      = !w_halt_op && !w_to_mem &&
                        (w_op <= 4'b0100 || w_op == 4'b1011 || w_op == 4'b1100);
  assign w_is_illegal = w_op == 4'b1101 || w_op == 4'b1110;
  assign w_wb_sel     = (w_op == 4'b1011 || w_op == 4'b1100) ? 2'b10 :
                        w_is_load ? 2'b01 : 2'b00;

  // Strobes are qualified with !rst so a reset mid-access drops them at once.
  assign w_fetch = !rst && r_state == S_FETCH;
  assign w_exec  = !rst && r_state == S_EXEC;
  assign w_mem   = !rst && r_state == S_MEM;
  assign w_wb    = !rst && r_state == S_WB;

  assign imem_req   = w_fetch;
  assign imem_addr  = r_pc;
  assign ir_out     = r_ir;
  assign opcode_out = w_op;
  assign pc_out     = r_pc;
  assign dmem_req   = w_mem;
  assign dmem_we    = w_mem && w_is_store;
  assign rf_we      = w_wb;
  assign wb_sel     = r_wb_sel;
  assign halted     = !rst && r_state == S_HALT;
  assign illegal    = w_exec && w_is_illegal;
  // EXEC retires everything that neither touches memory nor writes back (incl. halt).
  assign retire     = (w_exec && !w_to_mem && !w_to_wb) ||
                      (w_mem && dmem_ready && w_is_store) || w_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= 16'h0000;
      r_wb_sel <= 2'b00;
    end else begin
      case (r_state)
        S_FETCH: if (imem_ready) begin
          r_ir    <= imem_rdata;
          r_state <= S_DECODE;
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (!w_halt_op) r_pc <= next_pc_in;
          if (w_to_wb) r_wb_sel <= w_wb_sel;
          r_state <= w_halt_op ? S_HALT : w_to_mem ? S_MEM : w_to_wb ? S_WB : S_FETCH;
        end
        S_MEM: if (dmem_ready) begin
          if (w_is_load) r_wb_sel <= w_wb_sel;
          r_state <= w_is_load ? S_WB : S_FETCH;
        end
        S_WB: r_state <= S_FETCH;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end
endmodule
